deinterleave_block_output: RTL and testbench
============================================

Name: deinterleave_block_output

Overview:
Receives the slot-interleaved stream produced by the block interleaver and reassembles it into contiguous N-sample blocks, one block per channel.
- Input: one sample per clock; the channel (slot) index rotates 0..IIR-1 every clock; block_start marks sample 0 of a block.
- Each slot has two N-deep banks (ping-pong).
- Completed blocks are emitted back-to-back with a valid/ready handshake, in completion order.
- Sits at the receive end of the interleaved link, feeding per-channel block processors.

Parameters:
BITS, 8, sample width
IIR, 3, number of interleaved channels (slots), >=2
N, 10, samples per block, >=2

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  data_in is valid for the current slot
block_start  input  1  with in_valid: data_in is sample 0 of a new block for the current slot
data_in  input  BITS  input sample
out_ready  input  1  downstream accepts data_out this cycle
out_valid  output  1  data_out/out_set/out_block_start are valid
out_block_start  output  1  data_out is sample 0 of a block
out_set  output  $clog2(IIR)  slot the current output block came from
data_out  output  BITS  output sample
overflow  output  1  one-cycle pulse: a block was dropped because its target bank was still full
restart  output  1  one-cycle pulse: block_start arrived mid-block and the partial block was discarded

Behaviour:
- Reset (async, while rst=1):
  - All outputs are 0.
  - Slot counter is 0; every slot is idle with wr_bank=0 and wr_count=0.
  - All bank_full flags and the completion queue are cleared; the output state machine is IDLE.
- Slot counter: increments every clock regardless of in_valid and wraps IIR-1 -> 0. The first clock edge after rst falls samples slot 0.
- Per-slot write, for the slot currently selected:
  - Idle slot, in_valid=1 with block_start=0: sample dropped, no flag.
  - block_start=1 with in_valid=1:
    - If bank[wr_bank] is full: overflow pulses for 1 cycle, the slot goes idle and the block is dropped.
    - Otherwise, if the slot is active, restart pulses for 1 cycle; the partial data is discarded and the write restarts in the same bank.
    - In both non-overflow cases the sample is written at index 0, wr_count=1 and the slot becomes active.
  - Active slot, in_valid=1 with block_start=0: sample written at index wr_count, then wr_count increments.
  - Completion: on the write of index N-1:
    - bank_full[wr_bank] is set;
    - {slot, bank} is pushed to the completion queue;
    - wr_bank toggles, wr_count=0 and the slot goes idle.
  - Active slot, in_valid=0: no change. Gaps are allowed and the block continues on the slot's next valid sample.
- Completion queue: FIFO of depth 2*IIR. It cannot overflow because each bank occupies at most one entry.
- Output state machine:
  - IDLE: if the queue is non-empty, pop the head, set rd_count=0 and go to READ.
  - READ: present bank[slot][rd_count] on data_out, out_set=slot, out_valid=1, out_block_start=(rd_count==0).
  - Outputs are held stable while out_valid=1 and out_ready=0.
  - On out_valid && out_ready: rd_count increments.
  - On acceptance of rd_count==N-1: clear bank_full for that bank. If the queue is non-empty, pop the next entry and stay in READ with no bubble; otherwise go to IDLE and drop out_valid next cycle.
- Latency: with the queue empty and the state machine IDLE, out_valid rises exactly 2 clocks after the edge that writes sample N-1, with out_block_start=1.
- Simultaneous events:
  - The output reading a bank and the input completing a different bank in the same cycle are independent.
  - bank_full clear and a block_start to that same bank in the same cycle: the clear wins and the block is accepted.
- Read/write hazard: writes never target a bank with bank_full=1, so a bank being read is never overwritten.
- Width rules: wr_count and rd_count are $clog2(N)+1 bits. Slot and out_set are $clog2(IIR) bits. No arithmetic on data.

Optional Feature:
Macro DEINTERLEAVE_STATS_EN.
- Defined: adds outputs blocks_out[15:0] and blocks_dropped[15:0].
  - blocks_out increments on acceptance of each block's last sample.
  - blocks_dropped increments on each overflow pulse.
  - Both saturate at 16'hFFFF and are cleared by rst.
- Undefined: neither port nor any counter logic exists; all other behaviour is identical.

Test Plan:
1. Defaults, out_ready=1, three full interleaved blocks fed over 30 clocks with slot s sample k = 8'(s*16+k) -> slot 0 block out first as 0x00..0x09, out_set=0, out_block_start only on 0x00; then slots 1 and 2; 30 contiguous out_valid cycles.
2. Same stimulus with out_ready=0 for 40 cycles -> data_out holds 0x00; then 30 in-order accepted samples, no overflow.
3. out_ready=0, three consecutive blocks sent to slot 1 -> first two are stored; the third block_start pulses overflow once; later release outputs exactly 2 slot-1 blocks.
4. Slot 2 receives 4 samples, then block_start with value 0xAA -> restart pulses once; the emitted slot-2 block begins 0xAA and is N samples long.
5. Assert rst asynchronously mid-output -> all outputs 0 immediately, the queue is emptied, and after release the next full block is emitted normally.
6. in_valid toggling 50% on all slots -> each block completes and emits intact, with latency 2 clocks from the last write.

Source files
------------

// File: rtl/deinterleave_block_output_if.sv
// Bus of the block deinterleaver: interleaved sample stream in, contiguous
// per-slot blocks out with valid/ready, plus overflow/restart event pulses.
// Optional macro DEINTERLEAVE_STATS_EN adds the blocks_out/blocks_dropped counters.
interface deinterleave_block_output_if #(
    parameter int BITS = 8,
    parameter int IIR  = 3
);
    logic                   in_valid;
    logic                   block_start;
    logic [BITS-1:0]        data_in;
    logic                   out_ready;
    logic                   out_valid;
    logic                   out_block_start;
    logic [$clog2(IIR)-1:0] out_set;
    logic [BITS-1:0]        data_out;
    logic                   overflow;
    logic                   restart;
`ifdef DEINTERLEAVE_STATS_EN
    logic [15:0]            blocks_out;
    logic [15:0]            blocks_dropped;

    modport master (
        output in_valid, block_start, data_in, out_ready,
        input  out_valid, out_block_start, out_set, data_out, overflow, restart,
        input  blocks_out, blocks_dropped
    );
    modport slave (
        input  in_valid, block_start, data_in, out_ready,
        output out_valid, out_block_start, out_set, data_out, overflow, restart,
        output blocks_out, blocks_dropped
    );
`else
    modport master (
        output in_valid, block_start, data_in, out_ready,
        input  out_valid, out_block_start, out_set, data_out, overflow, restart
    );
    modport slave (
        input  in_valid, block_start, data_in, out_ready,
        output out_valid, out_block_start, out_set, data_out, overflow, restart
    );
`endif
endinterface

// File: rtl/deinterleave_block_output.sv
// Block deinterleaver: collects the slot-rotating sample stream into two
// ping-pong banks per slot and replays completed blocks back-to-back, in
// completion order, through a valid/ready output.
// Optional macro DEINTERLEAVE_STATS_EN adds saturating block statistics.
module deinterleave_block_output #(
    parameter int BITS = 8,
    parameter int IIR  = 3,
    parameter int N    = 10
) (
    input  logic clk,
    input  logic rst,
    deinterleave_block_output_if.slave bus
);
    localparam int SW  = $clog2(IIR);
    localparam int CW  = $clog2(N) + 1;
    localparam int NB  = 2 * IIR;
    localparam int AW  = $clog2(NB * N);
    localparam int QW  = $clog2(NB);
    localparam int QCW = $clog2(NB + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READ} state_t;

    // Bank id is {slot, bank}; banks are laid out contiguously, N samples each.
    function automatic logic [AW-1:0] f_addr(input logic [SW:0] bank_id, input logic [CW-1:0] idx);
        f_addr = AW'(int'(bank_id) * N + int'(idx));
    endfunction

    logic [BITS-1:0] r_mem [NB*N];
    logic [SW:0]     r_q [NB];

    logic [SW-1:0]   r_slot;
    logic [IIR-1:0]  r_active;
    logic [IIR-1:0]  r_wr_bank;
    logic [CW-1:0]   r_wr_count [IIR];
    logic [NB-1:0]   r_bank_full;
    logic [QW-1:0]   r_q_wp;
    logic [QW-1:0]   r_q_rp;
    logic [QCW-1:0]  r_q_cnt;
    logic            r_overflow;
    logic            r_restart;

    state_t          r_state;
    logic [SW-1:0]   r_rd_slot;
    logic            r_rd_bank;
    logic [CW-1:0]   r_rd_count;
    logic            r_out_valid;
    logic            r_out_bs;
    logic [SW-1:0]   r_out_set;
    logic [BITS-1:0] r_data_out;

    logic [SW:0]     w_cur_id;
    logic            w_cur_full;
    logic            w_we;
    logic [CW-1:0]   w_widx;
    logic            w_ovf;
    logic            w_rst_evt;
    logic            w_complete;
    logic            w_push;
    logic [SW:0]     w_rd_id;
    logic [CW-1:0]   w_rd_next;
    logic            w_last_acc;
    logic [NB-1:0]   w_clr_vec;
    logic [SW:0]     w_q_head;
    logic            w_q_ne;
    logic            w_pop;

    assign w_rd_id    = {r_rd_slot, r_rd_bank};
    assign w_rd_next  = r_rd_count + CW'(1);
    assign w_last_acc = (r_state == S_READ) && bus.out_ready && (r_rd_count == CW'(N - 1));
    // A bank freed this cycle is already writable this cycle.
    assign w_clr_vec  = w_last_acc ? (NB'(1) << w_rd_id) : '0;
    assign w_q_head   = r_q[r_q_rp];
    assign w_q_ne     = (r_q_cnt != '0);
    assign w_pop      = ((r_state == S_IDLE) || w_last_acc) && w_q_ne;
    assign w_push     = w_we && w_complete;

    // Decode what the current slot's sample does to its write state.
    always_comb begin
        w_cur_id   = {r_slot, r_wr_bank[r_slot]};
        w_cur_full = r_bank_full[w_cur_id] & ~w_clr_vec[w_cur_id];
        w_we       = 1'b0;
        w_widx     = '0;
        w_ovf      = 1'b0;
        w_rst_evt  = 1'b0;
        w_complete = 1'b0;
        if (bus.in_valid && bus.block_start) begin
            if (w_cur_full) begin
                w_ovf = 1'b1;
            end else begin
                w_we      = 1'b1;
                w_rst_evt = r_active[r_slot];
            end
        end else if (bus.in_valid && r_active[r_slot]) begin
            w_we       = 1'b1;
            w_widx     = r_wr_count[r_slot];
            w_complete = (r_wr_count[r_slot] == CW'(N - 1));
        end
    end

    // Slot rotation and per-slot write state (active / bank / count).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot     <= '0;
            r_active   <= '0;
            r_wr_bank  <= '0;
            r_overflow <= 1'b0;
            r_restart  <= 1'b0;
            for (int i = 0; i < IIR; i++) r_wr_count[i] <= '0;
        end else begin
            r_slot     <= (r_slot == SW'(IIR - 1)) ? '0 : r_slot + SW'(1);
            r_overflow <= w_ovf;
            r_restart  <= w_rst_evt;
            if (w_ovf) begin
                r_active[r_slot] <= 1'b0;
            end else if (w_we) begin
                if (w_complete) begin
                    r_active[r_slot]   <= 1'b0;
                    r_wr_bank[r_slot]  <= ~r_wr_bank[r_slot];
                    r_wr_count[r_slot] <= '0;
                end else begin
                    r_active[r_slot]   <= 1'b1;
                    r_wr_count[r_slot] <= w_widx + CW'(1);
                end
            end
        end
    end

    // Bank-full flags and completion-queue pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bank_full <= '0;
            r_q_wp      <= '0;
            r_q_rp      <= '0;
            r_q_cnt     <= '0;
        end else begin
            r_bank_full <= (r_bank_full & ~w_clr_vec) | (w_push ? (NB'(1) << w_cur_id) : '0);
            if (w_push) r_q_wp <= (r_q_wp == QW'(NB - 1)) ? '0 : r_q_wp + QW'(1);
            if (w_pop)  r_q_rp <= (r_q_rp == QW'(NB - 1)) ? '0 : r_q_rp + QW'(1);
            case ({w_push, w_pop})
                2'b10:   r_q_cnt <= r_q_cnt + QCW'(1);
                2'b01:   r_q_cnt <= r_q_cnt - QCW'(1);
                default: r_q_cnt <= r_q_cnt;
            endcase
        end
    end

    // Sample storage and queue entries carry no reset.
    always_ff @(posedge clk) begin
        if (w_we)   r_mem[f_addr(w_cur_id, w_widx)] <= bus.data_in;
        if (w_push) r_q[r_q_wp] <= w_cur_id;
    end

    // Output FSM: pop a block, prefetch sample 0, then stream with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rd_slot   <= '0;
            r_rd_bank   <= 1'b0;
            r_rd_count  <= '0;
            r_out_valid <= 1'b0;
            r_out_bs    <= 1'b0;
            r_out_set   <= '0;
            r_data_out  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_q_ne) begin
                        {r_rd_slot, r_rd_bank} <= w_q_head;
                        r_rd_count             <= '0;
                        r_state                <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_out_valid <= 1'b1;
                    r_out_bs    <= 1'b1;
                    r_out_set   <= r_rd_slot;
                    r_data_out  <= r_mem[f_addr(w_rd_id, CW'(0))];
                    r_state     <= S_READ;
                end
                S_READ: begin
                    if (w_last_acc) begin
                        if (w_q_ne) begin
                            {r_rd_slot, r_rd_bank} <= w_q_head;
                            r_rd_count             <= '0;
                            r_out_bs               <= 1'b1;
                            r_out_set              <= w_q_head[SW:1];
                            r_data_out             <= r_mem[f_addr(w_q_head, CW'(0))];
                        end else begin
                            r_out_valid <= 1'b0;
                            r_out_bs    <= 1'b0;
                            r_state     <= S_IDLE;
                        end
                    end else if (bus.out_ready) begin
                        r_rd_count <= w_rd_next;
                        r_out_bs   <= 1'b0;
                        r_data_out <= r_mem[f_addr(w_rd_id, w_rd_next)];
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.out_valid       = r_out_valid;
    assign bus.out_block_start = r_out_bs;
    assign bus.out_set         = r_out_set;
    assign bus.data_out        = r_data_out;
    assign bus.overflow        = r_overflow;
    assign bus.restart         = r_restart;

`ifdef DEINTERLEAVE_STATS_EN
    logic [15:0] r_blocks_out;
    logic [15:0] r_blocks_dropped;

    // Saturating counts of emitted and dropped blocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blocks_out     <= '0;
            r_blocks_dropped <= '0;
        end else begin
            if (w_last_acc && (r_blocks_out != 16'hFFFF))   r_blocks_out     <= r_blocks_out + 16'd1;
            if (w_ovf && (r_blocks_dropped != 16'hFFFF))    r_blocks_dropped <= r_blocks_dropped + 16'd1;
        end
    end

    assign bus.blocks_out     = r_blocks_out;
    assign bus.blocks_dropped = r_blocks_dropped;
`endif
endmodule

// File: tb/tb_deinterleave_block_output.sv
// Directed bench for deinterleave_block_output (BITS=8, IIR=3, N=10).
module tb_deinterleave_block_output;
    localparam int BITS = 8;
    localparam int IIR  = 3;
    localparam int N    = 10;

    typedef struct packed {
        logic [1:0] set;
        logic       bs;
        logic [7:0] d;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   tb_slot  = 0;
    int   t_last0  = 0;
    int   cyc      = 0;
    int   n_ovf    = 0;
    int   n_rst    = 0;
    int   rise_cyc = 0;
    int   fall_cyc = 0;
    logic prev_v   = 1'b0;
    obs_t got[$];

    always #5 clk = ~clk;

    deinterleave_block_output_if #(.BITS(BITS), .IIR(IIR)) bus ();

    deinterleave_block_output #(.BITS(BITS), .IIR(IIR), .N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard capture of accepted samples and event pulses.
    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready)
            got.push_back(obs_t'({bus.out_set, bus.out_block_start, bus.data_out}));
        if (bus.overflow) n_ovf <= n_ovf + 1;
        if (bus.restart)  n_rst <= n_rst + 1;
        if (bus.out_valid && !prev_v) rise_cyc <= cyc;
        if (!bus.out_valid && prev_v) fall_cyc <= cyc;
        prev_v <= bus.out_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input logic v, input logic bs, input logic [7:0] d);
        bus.in_valid    = v;
        bus.block_start = bs;
        bus.data_in     = d;
        @(posedge clk);
        #1;
        tb_slot = (tb_slot + 1) % IIR;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_to(input int s, input logic bs, input logic [7:0] d);
        while (tb_slot != s) tick(1'b0, 1'b0, 8'h00);
        tick(1'b1, bs, d);
    endtask

    task automatic send_block(input int s, input logic [7:0] b);
        for (int k = 0; k < N; k++) send_to(s, (k == 0), 8'(b + k));
    endtask

    task automatic send_frame(input logic [7:0] off);
        while (tb_slot != 0) tick(1'b0, 1'b0, 8'h00);
        for (int k = 0; k < N; k++)
            for (int s = 0; s < IIR; s++) begin
                tick(1'b1, (k == 0), 8'(off + s * 16 + k));
                if (k == N - 1 && s == 0) t_last0 = cyc;
            end
    endtask

    task automatic check_block(input string tag, input int base, input logic [1:0] set,
                               input logic [7:0] first, input logic [7:0] b);
        for (int k = 0; k < N; k++) begin
            obs_t e;
            obs_t o;
            e.set = set;
            e.bs  = (k == 0);
            e.d   = (k == 0) ? first : 8'(b + k);
            if (base + k < got.size()) o = got[base + k];
            else                       o = 'x;
            check($sformatf("%s[%0d]", tag, k), 32'(o), 32'(e));
        end
    endtask

    initial begin
        int base;
        int o0;
        int r0;
        int e0;
        int c;
        int kk[3];

        bus.in_valid    = 1'b0;
        bus.block_start = 1'b0;
        bus.data_in     = 8'h00;
        bus.out_ready   = 1'b1;
        rst             = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_bs", 32'(bus.out_block_start), 0);
        check("rst_out_set", 32'(bus.out_set), 0);
        check("rst_data_out", 32'(bus.data_out), 0);
        check("rst_overflow", 32'(bus.overflow), 0);
        check("rst_restart", 32'(bus.restart), 0);
        rst     = 1'b0;
        tb_slot = 0;

        // Test 1: three interleaved blocks, ready always high.
        base = got.size(); o0 = n_ovf;
        send_frame(8'h00);
        idle(40);
        check("t1_count", got.size() - base, 30);
        check_block("t1_s0", base,      2'd0, 8'h00, 8'h00);
        check_block("t1_s1", base + 10, 2'd1, 8'h10, 8'h10);
        check_block("t1_s2", base + 20, 2'd2, 8'h20, 8'h20);
        check("t1_latency", rise_cyc, t_last0 + 2);
        check("t1_contig", fall_cyc - rise_cyc, 30);
        check("t1_ovf", n_ovf - o0, 0);

        // Test 2: same stream with backpressure, output holds sample 0 of slot 0.
        bus.out_ready = 1'b0;
        base = got.size(); o0 = n_ovf;
        send_frame(8'h00);
        idle(10);
        check("t2_hold_valid", 32'(bus.out_valid), 1);
        check("t2_hold_data", 32'(bus.data_out), 32'h00);
        check("t2_hold_bs", 32'(bus.out_block_start), 1);
        check("t2_hold_none", got.size() - base, 0);
        bus.out_ready = 1'b1;
        idle(40);
        check("t2_count", got.size() - base, 30);
        check_block("t2_s0", base,      2'd0, 8'h00, 8'h00);
        check_block("t2_s1", base + 10, 2'd1, 8'h10, 8'h10);
        check_block("t2_s2", base + 20, 2'd2, 8'h20, 8'h20);
        check("t2_ovf", n_ovf - o0, 0);

        // Test 3: three blocks to slot 1 while stalled, third overflows.
        bus.out_ready = 1'b0;
        base = got.size(); o0 = n_ovf; r0 = n_rst;
        send_block(1, 8'h40);
        send_block(1, 8'h50);
        send_block(1, 8'h60);
        idle(3);
        check("t3_ovf", n_ovf - o0, 1);
        check("t3_restart", n_rst - r0, 0);
        bus.out_ready = 1'b1;
        idle(40);
        check("t3_count", got.size() - base, 20);
        check_block("t3_a", base,      2'd1, 8'h40, 8'h40);
        check_block("t3_b", base + 10, 2'd1, 8'h50, 8'h50);

        // Test 4: block_start mid-block on slot 2 restarts the block.
        base = got.size(); o0 = n_ovf; r0 = n_rst;
        send_to(2, 1'b1, 8'h10);
        send_to(2, 1'b0, 8'h11);
        send_to(2, 1'b0, 8'h12);
        send_to(2, 1'b0, 8'h13);
        send_to(2, 1'b1, 8'hAA);
        for (int k = 1; k < N; k++) send_to(2, 1'b0, 8'(8'h20 + k));
        idle(20);
        check("t4_restart", n_rst - r0, 1);
        check("t4_ovf", n_ovf - o0, 0);
        check("t4_count", got.size() - base, 10);
        check_block("t4_s2", base, 2'd2, 8'hAA, 8'h20);

        // Test 5: asynchronous reset while a block is presented.
        bus.out_ready = 1'b0;
        send_frame(8'h30);
        idle(5);
        check("t5_pre_valid", 32'(bus.out_valid), 1);
        check("t5_pre_data", 32'(bus.data_out), 32'h30);
        #3;
        rst = 1'b1;
        #1;
        check("t5_rst_valid", 32'(bus.out_valid), 0);
        check("t5_rst_bs", 32'(bus.out_block_start), 0);
        check("t5_rst_set", 32'(bus.out_set), 0);
        check("t5_rst_data", 32'(bus.data_out), 0);
        check("t5_rst_ovf", 32'(bus.overflow), 0);
        check("t5_rst_restart", 32'(bus.restart), 0);
        @(posedge clk);
        #1;
        rst           = 1'b0;
        tb_slot       = 0;
        bus.out_ready = 1'b1;
        base = got.size();
        idle(20);
        check("t5_queue_empty", got.size() - base, 0);
        send_block(2, 8'hC0);
        idle(20);
        check("t5_count", got.size() - base, 10);
        check_block("t5_s2", base, 2'd2, 8'hC0, 8'hC0);

        // Test 6: in_valid at 50% duty on all slots.
        while (tb_slot != 0) tick(1'b0, 1'b0, 8'h00);
        base = got.size();
        kk = '{0, 0, 0};
        e0 = -1;
        c  = 0;
        while ((kk[0] < N || kk[1] < N || kk[2] < N) && c < 200) begin
            int s;
            s = tb_slot;
            if ((c % 2 == 0) && kk[s] < N) begin
                tick(1'b1, (kk[s] == 0), 8'(s * 32 + 8'h40 + kk[s]));
                kk[s]++;
                if (kk[s] == N && e0 < 0) e0 = cyc;
            end else begin
                tick(1'b0, 1'b0, 8'h00);
            end
            c++;
        end
        idle(40);
        check("t6_count", got.size() - base, 30);
        check("t6_latency", rise_cyc, e0 + 2);
        check("t6_contig", fall_cyc - rise_cyc, 30);
        check_block("t6_s0", base,      2'd0, 8'h40, 8'h40);
        check_block("t6_s2", base + 10, 2'd2, 8'h80, 8'h80);
        check_block("t6_s1", base + 20, 2'd1, 8'h60, 8'h60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
